jtframe_resync_ctl: RTL and testbench

Sequencing controller for the sync-resync datapath. It measures incoming video timing (pixels per line, lines per frame) and declares lock after a run of consistent frames. It applies user-requested H/V sync offsets one step per frame, only at frame boundaries. While unlocked it forces both offsets to zero, so the resync datapath never runs with a shifted sync on an unstable or changing video mode.

---
 rtl/jtframe_video_pkg.sv | 36 +++
 rtl/jtframe_vidmeasure.sv | 135 +++++++++++++
 rtl/jtframe_resync_ctl.sv | 141 ++++++++++++++
 tb/tb_jtframe_resync_ctl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_video_pkg.sv
// Shared types and helpers for the video timing / resync control blocks.
//
// Contents:
//   state_t      - sequencing controller states (IDLE, MEASURE, LOCKED)
//   offset_t     - signed 4-bit sync offset (-8..+7)
//   cnt_max()    - all-ones saturation value for a counter of a given width
//   step_toward()- move an offset one step toward a requested value
package jtframe_video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  typedef logic signed [3:0] offset_t;

  // Saturation value of a w-bit counter (all ones)
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

  // One +1/-1 step toward the request; holds when already equal.
  // Requests are always in range, so stepping never wraps.
  function automatic offset_t step_toward(input offset_t cur, input offset_t req);
    offset_t res;
    if (req > cur)
      res = cur + 4'sd1;
    else if (req < cur)
      res = cur - 4'sd1;
    else
      res = cur;
    return res;
  endfunction

endpackage

// File: rtl/jtframe_vidmeasure.sv
// Video timing measurement for the resync controller.
//
// Detects rising edges of LHBL/LVBL (sampled on pxl_cen), counts pixels per
// line and lines per frame with saturating counters, and at each frame
// boundary captures the measured totals and reports whether the frame that
// just ended was valid and matched the previous one.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   pxl_cen      - pixel clock enable; nothing updates while low
//   LHBL, LVBL   - active-low horizontal / vertical blank
//   htotal       - last measured pixels per line
//   vtotal       - last measured lines per frame
//   frame_done   - single-cycle strobe on the LVBL rising edge
//   frame_valid  - ending frame had no saturation and non-zero totals
//   frame_match  - ending frame agrees with the stored htotal/vtotal
module jtframe_vidmeasure
  import jtframe_video_pkg::*;
#(
  parameter int CNTW = 10,
  parameter int VTOL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pxl_cen,
  input  logic            LHBL,
  input  logic            LVBL,
  output logic [CNTW-1:0] htotal,
  output logic [CNTW-1:0] vtotal,
  output logic            frame_done,
  output logic            frame_valid,
  output logic            frame_match
);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(cnt_max(CNTW));
  localparam logic [CNTW-1:0] ONE     = CNTW'(1);
  localparam logic [CNTW-1:0] TOL     = CNTW'(VTOL);

  logic            lhbl_last, lvbl_last;
  logic            hb_edge, vb_edge;
  logic [CNTW-1:0] hcnt, vcnt;
  logic [CNTW-1:0] last_len;
  logic [CNTW-1:0] line_now;
  logic [CNTW-1:0] frame_lines;
  logic [CNTW-1:0] vdiff;
  logic            hsat, vsat;

  // Edges only count when pxl_cen is high, so blank toggles during a
  // disabled stretch are invisible.
  assign hb_edge = pxl_cen & LHBL & ~lhbl_last;
  assign vb_edge = pxl_cen & LVBL & ~lvbl_last;

  // A line edge landing in the same cycle as the frame edge belongs to the
  // frame that is ending, both for its length and its line count.
  assign line_now    = hb_edge ? (hcnt + ONE) : last_len;
  assign frame_lines = vcnt + (hb_edge ? ONE : '0);

  assign vdiff = (frame_lines >= vtotal) ? (frame_lines - vtotal)
                                         : (vtotal - frame_lines);

  // Compared against the stored totals before they are overwritten
  assign frame_done  = vb_edge;
  assign frame_match = (line_now == htotal) && (vdiff <= TOL);
  assign frame_valid = ~hsat & ~vsat & (line_now != '0) & (frame_lines != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_last <= 1'b0;
      lvbl_last <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_last <= LHBL;
      lvbl_last <= LVBL;
    end
  end

  // Pixel counter: restarts on each line, sticks at all-ones if the line
  // edge never comes (LHBL stuck).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      last_len <= '0;
    end else if (pxl_cen) begin
      if (hb_edge) begin
        hcnt     <= '0;
        last_len <= line_now;
      end else if (hcnt != CNT_MAX) begin
        hcnt <= hcnt + ONE;
      end
    end
  end

  // Line counter: restarts on each frame, sticks at all-ones if the frame
  // edge never comes (LVBL missing).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt <= '0;
    end else if (pxl_cen) begin
      if (vb_edge)
        vcnt <= '0;
      else if (hb_edge && vcnt != CNT_MAX)
        vcnt <= vcnt + ONE;
    end
  end

  // Saturation flags remember any overflow during the frame and are
  // consumed at the frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsat <= 1'b0;
      vsat <= 1'b0;
    end else if (pxl_cen) begin
      if (vb_edge) begin
        hsat <= 1'b0;
        vsat <= 1'b0;
      end else begin
        if (!hb_edge && hcnt == CNT_MAX)
          hsat <= 1'b1;
        if (hb_edge && vcnt == CNT_MAX)
          vsat <= 1'b1;
      end
    end
  end

  // Totals captured together at the frame edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      htotal <= '0;
      vtotal <= '0;
    end else if (vb_edge) begin
      htotal <= line_now;
      vtotal <= frame_lines;
    end
  end

endmodule

// File: rtl/jtframe_resync_ctl.sv
// Sequencing controller for the sync-resync datapath.
//
// Measures the incoming video timing, declares lock after LOCK_FRAMES
// consistent frames, then walks the applied H/V sync offsets one step per
// frame toward the requested values. Offsets only change at frame edges and
// are forced to zero whenever the timing is not locked.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   pxl_cen             - pixel clock enable; all state holds while low
//   LHBL, LVBL          - active-low horizontal / vertical blank
//   hoff_req, voff_req  - requested signed offsets (-8..+7)
//   hoffset, voffset    - applied signed offsets
//   locked              - timing stable, offsets live
//   htotal, vtotal      - last measured pixels per line / lines per frame
module jtframe_resync_ctl
  import jtframe_video_pkg::*;
#(
  parameter int CNTW        = 10,
  parameter int LOCK_FRAMES = 4,
  parameter int VTOL        = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pxl_cen,
  input  logic            LHBL,
  input  logic            LVBL,
  input  logic [3:0]      hoff_req,
  input  logic [3:0]      voff_req,
  output logic [3:0]      hoffset,
  output logic [3:0]      voffset,
  output logic            locked,
  output logic [CNTW-1:0] htotal,
  output logic [CNTW-1:0] vtotal
);

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_FRAMES - 1);

  state_t     state, state_nx;
  logic [3:0] mcnt, mcnt_nx;
  offset_t    hoff, hoff_nx;
  offset_t    voff, voff_nx;
  logic       locked_nx;
  logic       frame_done, frame_valid, frame_match;
  logic       frame_good;

  jtframe_vidmeasure #(
    .CNTW (CNTW),
    .VTOL (VTOL)
  ) u_measure (
    .clk         (clk),
    .rst_n       (rst_n),
    .pxl_cen     (pxl_cen),
    .LHBL        (LHBL),
    .LVBL        (LVBL),
    .htotal      (htotal),
    .vtotal      (vtotal),
    .frame_done  (frame_done),
    .frame_valid (frame_valid),
    .frame_match (frame_match)
  );

  assign frame_good = frame_valid & frame_match;

  assign hoffset = hoff;
  assign voffset = voff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mcnt   <= '0;
      hoff   <= '0;
      voff   <= '0;
      locked <= 1'b0;
    end else begin
      state  <= state_nx;
      mcnt   <= mcnt_nx;
      hoff   <= hoff_nx;
      voff   <= voff_nx;
      locked <= locked_nx;
    end
  end

  // Everything moves only on frame_done, which already includes pxl_cen,
  // so offsets can never jump in the middle of a frame.
  always_comb begin
    state_nx  = state;
    mcnt_nx   = mcnt;
    hoff_nx   = hoff;
    voff_nx   = voff;
    locked_nx = locked;
    if (frame_done) begin
      case (state)
        // The first edge only seeds the stored totals
        ST_IDLE: begin
          state_nx  = ST_MEASURE;
          mcnt_nx   = '0;
          hoff_nx   = '0;
          voff_nx   = '0;
          locked_nx = 1'b0;
        end
        ST_MEASURE: begin
          hoff_nx   = '0;
          voff_nx   = '0;
          locked_nx = 1'b0;
          if (frame_good) begin
            if (mcnt == LOCK_LAST) begin
              state_nx  = ST_LOCKED;
              mcnt_nx   = '0;
              locked_nx = 1'b1;
            end else begin
              mcnt_nx = mcnt + 4'd1;
            end
          end else begin
            mcnt_nx = '0;
          end
        end
        ST_LOCKED: begin
          if (frame_good) begin
            hoff_nx = step_toward(hoff, $signed(hoff_req));
            voff_nx = step_toward(voff, $signed(voff_req));
          end else begin
            state_nx  = ST_MEASURE;
            mcnt_nx   = '0;
            hoff_nx   = '0;
            voff_nx   = '0;
            locked_nx = 1'b0;
          end
        end
        default: begin
          state_nx  = ST_IDLE;
          mcnt_nx   = '0;
          hoff_nx   = '0;
          voff_nx   = '0;
          locked_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_resync_ctl.sv
// Testbench for jtframe_resync_ctl.
//
// Frames are generated pixel by pixel: each line has h pixels with LHBL low
// for the last two, each frame has l lines with LVBL low for the last two, so
// both blanks rise together on the first pixel of every frame. Expected
// outputs in each vector describe the state right after that first pixel,
// i.e. after the edge that closes the previous frame. A second instance with
// VTOL=0 shares the stimulus for the interlaced case.
module tb_jtframe_resync_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pxl_cen;
  logic       LHBL, LVBL;
  logic [3:0] hoff_req, voff_req;

  logic [3:0] hoffset_a, voffset_a, hoffset_b, voffset_b;
  logic       locked_a, locked_b;
  logic [9:0] htotal_a, vtotal_a, htotal_b, vtotal_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int h;
    int l;
    int hreq;
    int vreq;
    bit chk_tot;
    int exp_locked;
    int exp_hoff;
    int exp_voff;
    int exp_ht;
    int exp_vt;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  jtframe_resync_ctl #(.CNTW(10), .LOCK_FRAMES(4), .VTOL(1)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .hoff_req (hoff_req),
    .voff_req (voff_req),
    .hoffset  (hoffset_a),
    .voffset  (voffset_a),
    .locked   (locked_a),
    .htotal   (htotal_a),
    .vtotal   (vtotal_a)
  );

  jtframe_resync_ctl #(.CNTW(10), .LOCK_FRAMES(4), .VTOL(0)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .hoff_req (hoff_req),
    .voff_req (voff_req),
    .hoffset  (hoffset_b),
    .voffset  (voffset_b),
    .locked   (locked_b),
    .htotal   (htotal_b),
    .vtotal   (vtotal_b)
  );

  // Guards against any unexpected stall of the stimulus
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int exp_locked,
                            input int exp_hoff, input int exp_voff);
    checkOutput($sformatf("%s locked", tag), int'(locked_a), exp_locked);
    checkOutput($sformatf("%s hoffset", tag), int'($signed(hoffset_a)), exp_hoff);
    checkOutput($sformatf("%s voffset", tag), int'($signed(voffset_a)), exp_voff);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    pxl_cen  = 1'b0;
    LHBL     = 1'b0;
    LVBL     = 1'b0;
    hoff_req = 4'd0;
    voff_req = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One full frame; checks at the opening pixel and at mid-frame.
  // exp_lock_b < 0 skips the VTOL=0 instance.
  task automatic runFrame(input int h, input int l, input int exp_locked,
                          input int exp_hoff, input int exp_voff, input bit chk_tot,
                          input int exp_ht, input int exp_vt, input int exp_lock_b,
                          input string tag);
    int n;
    int mid;
    n   = 0;
    mid = (h * l) / 2;
    pxl_cen = 1'b1;
    for (int line = 0; line < l; line++) begin
      for (int pix = 0; pix < h; pix++) begin
        LVBL = (line < l - 2);
        LHBL = (pix < h - 2);
        @(posedge clk);
        #1;
        if (n == 0) begin
          checkState($sformatf("%s open", tag), exp_locked, exp_hoff, exp_voff);
          if (chk_tot) begin
            checkOutput($sformatf("%s htotal", tag), int'(htotal_a), exp_ht);
            checkOutput($sformatf("%s vtotal", tag), int'(vtotal_a), exp_vt);
          end
          if (exp_lock_b >= 0)
            checkOutput($sformatf("%s locked_b", tag), int'(locked_b), exp_lock_b);
        end else if (n == mid) begin
          checkState($sformatf("%s mid", tag), exp_locked, exp_hoff, exp_voff);
        end
        n++;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    hoff_req = 4'(v.hreq);
    voff_req = 4'(v.vreq);
    runFrame(v.h, v.l, v.exp_locked, v.exp_hoff, v.exp_voff, v.chk_tot,
             v.exp_ht, v.exp_vt, -1, tag);
  endtask

  initial begin
    //         h   l  hreq vreq tot lck hoff voff  ht  vt
    vecs[0]  = '{12, 10, 0,  0, 0,  0,  0,  0,  0,  0};
    vecs[1]  = '{12, 10, 0,  0, 1,  0,  0,  0, 12, 10};
    vecs[2]  = '{12, 10, 0,  0, 1,  0,  0,  0, 12, 10};
    vecs[3]  = '{12, 10, 0,  0, 1,  0,  0,  0, 12, 10};
    vecs[4]  = '{12, 10, 0,  0, 1,  0,  0,  0, 12, 10};
    vecs[5]  = '{12, 10, 3, -2, 1,  1,  0,  0, 12, 10};
    vecs[6]  = '{12, 10, 3, -2, 1,  1,  1, -1, 12, 10};
    vecs[7]  = '{12, 10, 3, -2, 1,  1,  2, -2, 12, 10};
    vecs[8]  = '{12, 10, 3, -2, 1,  1,  3, -2, 12, 10};
    vecs[9]  = '{12, 10, 3, -2, 1,  1,  3, -2, 12, 10};
    vecs[10] = '{14, 10, 3, -2, 1,  1,  3, -2, 12, 10};
    vecs[11] = '{14, 10, 3, -2, 1,  0,  0,  0, 14, 10};
    vecs[12] = '{14, 10, 3, -2, 1,  0,  0,  0, 14, 10};
    vecs[13] = '{14, 10, 3, -2, 1,  0,  0,  0, 14, 10};
    vecs[14] = '{14, 10, 3, -2, 1,  0,  0,  0, 14, 10};
    vecs[15] = '{14, 10, 3, -2, 1,  1,  0,  0, 14, 10};
    vecs[16] = '{14, 10, 3, -2, 1,  1,  1, -1, 14, 10};
    vecs[17] = '{14, 10, 3, -2, 1,  1,  2, -2, 14, 10};
    vecs[18] = '{14, 10, 3, -2, 1,  1,  3, -2, 14, 10};

    // Reset values
    doReset();
    checkState("reset", 0, 0, 0);
    checkOutput("reset htotal", int'(htotal_a), 0);
    checkOutput("reset vtotal", int'(vtotal_a), 0);

    // Lock, ramp, line-length change, re-lock, ramp again
    for (int i = 0; i < 19; i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // pxl_cen low while locked: blank toggles must be ignored
    pxl_cen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      LHBL = i[0];
      LVBL = i[1];
      @(posedge clk);
    end
    LHBL = 1'b0;
    LVBL = 1'b0;
    #1;
    checkState("cen_hold", 1, 3, -2);
    checkOutput("cen_hold htotal", int'(htotal_a), 14);
    checkOutput("cen_hold vtotal", int'(vtotal_a), 10);

    // Asynchronous reset while locked, sampled before the next clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("async_rst", 0, 0, 0);
    checkOutput("async_rst htotal", int'(htotal_a), 0);
    checkOutput("async_rst vtotal", int'(vtotal_a), 0);

    // Fresh start; blank toggles with pxl_cen low must not seed anything
    doReset();
    for (int i = 0; i < 20; i++) begin
      LHBL = i[0];
      LVBL = i[1];
      @(posedge clk);
    end
    LHBL = 1'b0;
    LVBL = 1'b0;
    #1;
    checkState("post_rst_hold", 0, 0, 0);
    checkOutput("post_rst_hold htotal", int'(htotal_a), 0);
    checkOutput("post_rst_hold vtotal", int'(vtotal_a), 0);

    // Interlaced 11/10 lines: VTOL=1 locks on schedule, VTOL=0 never does
    for (int f = 0; f < 8; f++)
      runFrame(12, (f % 2 == 0) ? 11 : 10, (f >= 5) ? 1 : 0, 0, 0, 1'b0, 0, 0, 0,
               $sformatf("ilace%0d", f));

    // Missing LVBL edge: 2000-line frame saturates vcnt and drops lock
    doReset();
    hoff_req = 4'd1;
    voff_req = 4'd1;
    for (int f = 0; f < 6; f++)
      runFrame(12, 10, (f == 5) ? 1 : 0, 0, 0, 1'b0, 0, 0, -1, $sformatf("sat%0d", f));
    runFrame(12, 2000, 1, 1, 1, 1'b0, 0, 0, -1, "sat_long");
    runFrame(12, 10, 0, 0, 0, 1'b0, 0, 0, -1, "sat_drop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
